// File: rtl/dmem_swap_master.sv
`default_nettype none
// ============================================================================
// Module      : dmem_swap_master
// Description : Sequencer that swaps two 64-bit doublewords in data memory
//               (read A, read B, write A<-B, write B<-A, then done).
//               Optional macro SWAP_CMP_EN turns it into compare-and-swap.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_swap_master #(
    parameter int DEPTH_BYTES = 64,
    parameter int DATA_W      = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [63:0]       addr_a,
    input  logic [63:0]       addr_b,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              swapped,
    output logic [63:0]       address,
    output logic [DATA_W-1:0] write_data,
    output logic              memoryread,
    output logic              memorywrite,
    input  logic [DATA_W-1:0] read_data
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_WR_A = 3'd3,
        S_WR_B = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    localparam logic [63:0] C_MAX_ADDR = 64'(DEPTH_BYTES - 8);

    state_t            r_state;
    state_t            w_next;
    logic [63:0]       r_addr_a;
    logic [63:0]       r_addr_b;
    logic [DATA_W-1:0] r_reg_a;
    logic [DATA_W-1:0] r_reg_b;
    logic              r_err;
    logic              r_swapped;
    logic              w_bad;
    logic              w_take_swap;

    assign w_bad = (addr_a[2:0] != 3'b000) || (addr_a > C_MAX_ADDR) ||
                   (addr_b[2:0] != 3'b000) || (addr_b > C_MAX_ADDR);

`ifdef SWAP_CMP_EN
    // read_data holds B during RD_B; swap only when B sorts before A
    assign w_take_swap = (read_data < r_reg_a);
`else
    assign w_take_swap = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_addr_a  <= '0;
            r_addr_b  <= '0;
            r_reg_a   <= '0;
            r_reg_b   <= '0;
            r_err     <= 1'b0;
            r_swapped <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr_a  <= addr_a;
                        r_addr_b  <= addr_b;
                        r_err     <= w_bad;
                        r_swapped <= 1'b0;
                    end
                end
                S_RD_A: r_reg_a <= read_data;
                S_RD_B: begin
                    r_reg_b   <= read_data;
                    r_swapped <= w_take_swap;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next      = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        swapped     = 1'b0;
        address     = '0;
        write_data  = '0;
        memoryread  = 1'b0;
        memorywrite = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (w_bad || (addr_a == addr_b)) ? S_FIN : S_RD_A;
                end
            end
            S_RD_A: begin
                busy       = 1'b1;
                address    = r_addr_a;
                memoryread = 1'b1;
                w_next     = S_RD_B;
            end
            S_RD_B: begin
                busy       = 1'b1;
                address    = r_addr_b;
                memoryread = 1'b1;
                w_next     = w_take_swap ? S_WR_A : S_FIN;
            end
            // Reset masks the write strobe so an aborted write never commits
            S_WR_A: begin
                busy        = 1'b1;
                address     = r_addr_a;
                write_data  = r_reg_b;
                memorywrite = ~reset;
                w_next      = S_WR_B;
            end
            S_WR_B: begin
                busy        = 1'b1;
                address     = r_addr_b;
                write_data  = r_reg_a;
                memorywrite = ~reset;
                w_next      = S_FIN;
            end
            S_FIN: begin
                busy    = 1'b1;
                done    = 1'b1;
                err     = r_err;
                swapped = r_swapped;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_swap_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_swap_master
// Description : Self-checking bench for dmem_swap_master with a memory model
//               and a transaction-level reference of each swap request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_swap_master;

    localparam int DEPTH_BYTES = 64;

    typedef struct {
        int          cyc;
        logic [63:0] addr;
        bit          we;
        logic [63:0] data;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] addr_a;
    logic [63:0] addr_b;
    logic        busy;
    logic        done;
    logic        err;
    logic        swapped;
    logic [63:0] address;
    logic [63:0] write_data;
    logic        memoryread;
    logic        memorywrite;
    logic [63:0] read_data;

    logic [63:0] mem    [8];
    logic [63:0] ld_img [8];
    logic        ld_en = 1'b0;

    int   n_cmp = 0;
    int   n_bad = 0;
    acc_t exp_q[$];

    always #5 clk = ~clk;

    dmem_swap_master #(.DEPTH_BYTES(DEPTH_BYTES), .DATA_W(64)) dut (
        .clk(clk), .reset(reset), .start(start), .addr_a(addr_a), .addr_b(addr_b),
        .busy(busy), .done(done), .err(err), .swapped(swapped),
        .address(address), .write_data(write_data),
        .memoryread(memoryread), .memorywrite(memorywrite), .read_data(read_data)
    );

    always @(posedge clk) begin
        if (ld_en) mem <= ld_img;
        else if (memorywrite) mem[address[5:3]] <= write_data;
    end

    assign read_data = memoryread ? mem[address[5:3]] : 64'h0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_mem(input logic [63:0] v [8]);
        ld_img = v;
        ld_en  = 1'b1;
        @(negedge clk);
        ld_en  = 1'b0;
    endtask

    task automatic load_preload();
        logic [63:0] v [8];
        v = '{64'd15, 64'd2, 64'd1, 64'd44, 64'd100, 64'd6, 64'd7, 64'd8};
        load_mem(v);
    endtask

    task automatic load_random();
        logic [63:0] v [8];
        for (int i = 0; i < 8; i++) v[i] = {$urandom, $urandom};
        load_mem(v);
    endtask

    function automatic logic [63:0] pick_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)       return 64'($urandom_range(0, 7) * 8);
        else if (r == 7) return 64'($urandom_range(0, 63) | 1);
        else if (r == 8) return 64'(64 + 8 * $urandom_range(0, 4));
        else             return {1'b1, 31'($urandom), 32'($urandom)};
    endfunction

    // Reference: decide outcome from the request and the memory image, list
    // the expected bus accesses, and predict the final memory contents.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input int inj_cyc,
                          input logic [63:0] ia, input logic [63:0] ib);
        logic [63:0] snap [8];
        logic [63:0] va, vb;
        bit          ok_a, ok_b, do_sw, exp_err, exp_sw;
        int          exp_done, first_done, ndone;
        acc_t        e;
        snap = mem;
        exp_q.delete();
        exp_err  = 1'b0;
        exp_sw   = 1'b0;
        exp_done = 1;
        ok_a = (a % 8 == 0) && (a <= 64'(DEPTH_BYTES - 8));
        ok_b = (b % 8 == 0) && (b <= 64'(DEPTH_BYTES - 8));
        if (!ok_a || !ok_b) begin
            exp_err = 1'b1;
        end else if (a != b) begin
            va = snap[int'(a / 8)];
            vb = snap[int'(b / 8)];
            exp_q.push_back('{1, a, 1'b0, 64'h0});
            exp_q.push_back('{2, b, 1'b0, 64'h0});
`ifdef SWAP_CMP_EN
            do_sw = (vb < va);
`else
            do_sw = 1'b1;
`endif
            if (do_sw) begin
                exp_q.push_back('{3, a, 1'b1, vb});
                exp_q.push_back('{4, b, 1'b1, va});
                snap[int'(a / 8)] = vb;
                snap[int'(b / 8)] = va;
                exp_sw   = 1'b1;
                exp_done = 5;
            end else begin
                exp_done = 3;
            end
        end

        @(negedge clk);
        start  = 1'b1;
        addr_a = a;
        addr_b = b;
        first_done = 0;
        ndone      = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == inj_cyc && c < exp_done) begin
                start = 1'b1; addr_a = ia; addr_b = ib;
            end else begin
                start = 1'b0; addr_a = {$urandom, $urandom}; addr_b = {$urandom, $urandom};
            end
            #1;
            check($sformatf("busy_c%0d", c), busy, (c <= exp_done));
            if (memoryread || memorywrite) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("extra_access_c%0d", c), 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("acc_cycle", 64'(c), 64'(e.cyc));
                    check("acc_addr", address, e.addr);
                    check("acc_rd", memoryread, !e.we);
                    check("acc_wr", memorywrite, e.we);
                    if (e.we) check("acc_wdata", write_data, e.data);
                end
            end else begin
                check($sformatf("idle_bus_c%0d", c), {address, write_data}, 128'h0);
            end
            if (done) begin
                ndone++;
                if (first_done == 0) first_done = c;
                check("done_err", err, exp_err);
                check("done_swapped", swapped, exp_sw);
            end
        end
        check("done_cycle", 64'(first_done), 64'(exp_done));
        check("done_count", 64'(ndone), 64'd1);
        check("acc_left", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < 8; i++) check($sformatf("mem[%0d]", i * 8), mem[i], snap[i]);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        addr_a = '0;
        addr_b = '0;
        load_preload();
        @(negedge clk);
        #1;
        check("rst_ctrl", {busy, done, err, swapped, memoryread, memorywrite}, 6'b0);
        check("rst_bus", {address, write_data}, 128'h0);
        reset = 1'b0;

        // directed cases on the preloaded image
        run_op(64'd0, 64'd16, 0, 64'd0, 64'd0);
        check("swap_mem0", mem[0], 64'd1);
        check("swap_mem16", mem[2], 64'd15);
        run_op(64'd24, 64'd24, 0, 64'd0, 64'd0);
        run_op(64'd3, 64'd8, 0, 64'd0, 64'd0);
        run_op(64'd64, 64'd8, 0, 64'd0, 64'd0);
        load_preload();
        run_op(64'd8, 64'd40, 2, 64'd0, 64'd56);

        // reset in the second write cycle
        load_preload();
        @(negedge clk);
        start = 1'b1; addr_a = 64'd0; addr_b = 64'd8;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_wr_gate", memorywrite, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_mid_ctrl", {busy, done, err, swapped, memoryread, memorywrite}, 6'b0);
        check("rst_mid_bus", {address, write_data}, 128'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check("rst_no_done", done, 1'b0);
        end
        check("rst_mem0", mem[0], 64'd2);
        check("rst_mem8", mem[1], 64'd2);

        // reset wins over a simultaneous start
        @(negedge clk);
        reset = 1'b1; start = 1'b1; addr_a = 64'd0; addr_b = 64'd8;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        #1;
        check("rst_prio_busy", busy, 1'b0);
        check("rst_prio_rd", memoryread, 1'b0);

        load_preload();
        run_op(64'd0, 64'd8, 0, 64'd0, 64'd0);
        run_op(64'd16, 64'd24, 0, 64'd0, 64'd0);

        // randomized requests against the reference
        for (int n = 0; n < 30; n++) begin
            if (n % 6 == 0) load_random();
            run_op(pick_addr(), pick_addr(), ($urandom_range(0, 3) == 0) ? 2 : 0,
                   pick_addr(), pick_addr());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_swap_master.md
# dmem_swap_master

Initiator-side sequencer that drives the data-memory port (`address`, `write_data`, `memoryread`, `memorywrite`, `read_data`) to exchange two 64-bit doublewords in memory.
- Accepts a one-cycle `start` with two byte addresses.
- Performs read A, read B, write A←B, write B←A, then pulses `done`.
- Sits between the selection-sort control path and the data memory as the hardware swap step of each sort pass.

## Interface
Parameters:
- `DEPTH_BYTES`, 64: memory size in bytes; valid doubleword addresses are 0..DEPTH_BYTES-8.
- `DATA_W`, 64: doubleword width; fixed at 64.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `addr_a`  in  64  byte address of first doubleword.
- `addr_b`  in  64  byte address of second doubleword.
- `busy`  out  1  high from the cycle after an accepted `start` until the cycle `done` is high, inclusive.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse, coincident with `done`, for a rejected request.
- `swapped`  out  1  valid with `done`; 1 if writes were performed.
- `address`  out  64  memory byte address.
- `write_data`  out  64  memory write data.
- `memoryread`  out  1  memory read enable; the read is combinational in memory.
- `memorywrite`  out  1  memory write enable; the write commits at the rising edge.
- `read_data`  in  64  memory read data.

## Operation
- States: IDLE, RD_A, RD_B, WR_A, WR_B, FIN.
- **IDLE**
  - Latch `addr_a` and `addr_b` on `start`.
  - If either address has `addr[2:0]!=0` or `addr > DEPTH_BYTES-8`: go to FIN with `err` set. No memory access.
  - Else if `addr_a==addr_b`: go to FIN, no access, `swapped=0`.
  - Else: go to RD_A.
- **RD_A**: `address=A`, `memoryread=1`. Capture `read_data` into `reg_a` at the edge. Go to RD_B.
- **RD_B**: `address=B`, `memoryread=1`. Capture `read_data` into `reg_b` at the edge. Go to WR_A. Under `SWAP_CMP_EN`, go to FIN instead if the compare fails.
- **WR_A**: `address=A`, `write_data=reg_b`, `memorywrite=1`. Go to WR_B.
- **WR_B**: `address=B`, `write_data=reg_a`, `memorywrite=1`. Go to FIN.
- **FIN**: `done=1`, plus `err` and `swapped` as determined. Go to IDLE.
- Memory-side outputs are decoded only from the state register and the latched addresses/data. There is no combinational path from `start`, `addr_a` or `addr_b`.
- Outside RD/WR states: `address=0`, `write_data=0`, `memoryread=0`, `memorywrite=0`.
- `start` while not in IDLE is ignored and not queued.
- Address comparisons use the full 64 bits, unsigned.

## Timing
- Reset values: state IDLE; `busy`, `done`, `err`, `swapped`, `memoryread` and `memorywrite` all 0; `address` and `write_data` 0; `reg_a` and `reg_b` 0.
- Normal swap latency: `start` sampled at edge 0, then RD_A, RD_B, WR_A, WR_B in cycles 1–4, and `done` in cycle 5.
- New `start` is accepted at the earliest in the cycle after `done`.
- Rejected or same-address request: `done` (and `err` if rejected) in cycle 1.
- Memory writes commit at the end of cycles 3 and 4.
- Reset mid-operation:
  - Forces IDLE at that edge and deasserts `memorywrite` immediately.
  - A write already committed stays; the memory may hold a half-swapped pair.
  - No `done` is issued.
- `reset` has priority over `start` in the same cycle.

## Configuration
- `SWAP_CMP_EN` defined: compare-and-swap.
  - In RD_B, if unsigned `read_data < reg_a`, proceed to the writes with `swapped=1`.
  - Otherwise go to FIN with `swapped=0`, no writes, `done` in cycle 3.
- `SWAP_CMP_EN` undefined: unconditional swap.
  - `swapped=1` whenever the WR states execute.
  - `swapped=0` for same-address or rejected requests.

## Test plan
Memory is preloaded with doublewords 15, 2, 1, 44, 100, 6, 7, 8 at byte addresses 0, 8, …, 56.
- Swap `addr_a=0`, `addr_b=16` → `memoryread` in cycles 1–2, `memorywrite` in cycles 3–4, `done` in cycle 5; memory then holds mem[0]=1 and mem[16]=15, with `swapped=1` and `err=0`.
- `addr_a=24`, `addr_b=24` → `done` in cycle 1 with `swapped=0` and `err=0`; `memoryread` and `memorywrite` are never asserted.
- `addr_a=3` (misaligned) and `addr_a=64` (out of range), each with `addr_b=8` → `done` and `err` high in cycle 1, no memory access, memory unchanged.
- Second `start` (0, 56) issued in cycle 2 of the swap (8, 40) → ignored; only mem[8]=6 and mem[40]=2 change, and exactly one `done` pulse is seen.
- `reset` asserted in cycle 4 of the swap (0, 8) → next cycle is IDLE with all outputs 0 and no `done`; mem[0]=2 (already written) and mem[8]=2.
- `SWAP_CMP_EN`:
  - (0, 8), values 15 vs 2 → swap, `done` in cycle 5, `swapped=1`.
  - (16, 24), values 1 vs 44 → `done` in cycle 3, `swapped=0`, no `memorywrite`.
